// File: rtl/pwm_sched.sv
// Multi-channel PWM generator: per-period threshold reload from an external
// double-buffered memory, with host writes and commit-at-boundary buffer swaps.
module pwm_sched #(
    parameter int PWM_WIDTH = 16,
    parameter int NUM_PWM   = 4,
    localparam int AW       = (NUM_PWM > 1) ? $clog2(NUM_PWM) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [PWM_WIDTH-1:0] period,
    input  logic                 cfg_valid,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [PWM_WIDTH-1:0] cfg_data,
    output logic                 cfg_ready,
    input  logic                 commit,
    output logic                 commit_pending,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_waddr,
    output logic [PWM_WIDTH-1:0] mem_wdata,
    output logic                 mem_latch,
    output logic [AW-1:0]        mem_raddr,
    input  logic [PWM_WIDTH-1:0] mem_rdata,
    output logic [NUM_PWM-1:0]   pwm_out,
    output logic                 period_start,
    output logic [1:0]           dbg_state
);

    // Host write handshake: a write transfers on a rising edge where
    // cfg_valid && cfg_ready; out-of-range addresses transfer but are dropped.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [PWM_WIDTH-1:0] counter;
    logic [PWM_WIDTH-1:0] period_q;
    logic [PWM_WIDTH-1:0] thr [NUM_PWM];
    logic [AW-1:0]        load_idx;
    logic                 load_last;
    logic                 run_last;
    logic                 addr_ok;

    assign load_last = (load_idx == AW'(NUM_PWM - 1));
    assign run_last  = (counter == period_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = LATCH;
            LATCH:   state_nxt = LOAD;
            LOAD:    if (load_last) state_nxt = RUN;
            RUN:     if (run_last) state_nxt = LATCH;
            default: state_nxt = IDLE;
        endcase
        if (!enable) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter        <= '0;
            period_q       <= '0;
            load_idx       <= '0;
            commit_pending <= 1'b0;
            for (int i = 0; i < NUM_PWM; i++) thr[i] <= '0;
        end else begin
            // The swap for the old request happens this LATCH; a commit
            // arriving now targets the following boundary.
            if (state == LATCH)  commit_pending <= commit;
            else if (commit)     commit_pending <= 1'b1;

            if (state == LATCH) period_q <= period;
            if (state == LOAD)  thr[load_idx] <= mem_rdata;

            load_idx <= (state == LOAD && state_nxt == LOAD) ? load_idx + 1'b1 : '0;
            counter  <= (state == RUN && state_nxt == RUN) ? counter + 1'b1 : '0;
        end
    end

    assign addr_ok   = ({1'b0, cfg_addr} < (AW + 1)'(NUM_PWM));
    assign cfg_ready = !commit_pending && (state != LATCH);
    assign mem_we    = cfg_valid && cfg_ready && addr_ok;
    assign mem_waddr = cfg_addr;
    assign mem_wdata = cfg_data;
    assign mem_latch = (state == LATCH) && commit_pending;
    assign mem_raddr = (state == LOAD) ? load_idx : '0;

    assign period_start = (state == RUN) && (counter == '0);
    assign dbg_state    = state;

    always_comb begin
        pwm_out = '0;
        for (int i = 0; i < NUM_PWM; i++)
            pwm_out[i] = (state == RUN) && (counter < thr[i]);
    end

endmodule

// File: tb/tb_pwm_sched.sv
// Bench for pwm_sched: external double-buffered memory model, per-cycle
// expected-word scoreboard, and a table of host-write vectors.
module tb_pwm_sched;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int AW = 2;

    typedef logic [W-1:0] thr_t [N];

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic [W-1:0]   period = '0;
    logic           cfg_valid = 1'b0;
    logic [AW-1:0]  cfg_addr = '0;
    logic [W-1:0]   cfg_data = '0;
    logic           cfg_ready;
    logic           commit = 1'b0;
    logic           commit_pending;
    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [W-1:0]   mem_wdata;
    logic           mem_latch;
    logic [AW-1:0]  mem_raddr;
    logic [W-1:0]   mem_rdata;
    logic [N-1:0]   pwm_out;
    logic           period_start;
    logic [1:0]     dbg_state;

    // Second instance with a non-power-of-two channel count
    logic           en5 = 1'b0;
    logic [W-1:0]   period5 = '0;
    logic           cfg5_valid = 1'b0;
    logic [2:0]     cfg5_addr = '0;
    logic [W-1:0]   cfg5_data = '0;
    logic           cfg5_ready;
    logic           commit5 = 1'b0;
    logic           pending5;
    logic           mem5_we;
    logic [2:0]     mem5_waddr;
    logic [W-1:0]   mem5_wdata;
    logic           mem5_latch;
    logic [2:0]     mem5_raddr;
    logic [W-1:0]   mem5_rdata = '0;
    logic [4:0]     pwm5_out;
    logic           period5_start;
    logic [1:0]     dbg5_state;

    int checks = 0;
    int failures = 0;
    logic [9:0] exp_q[$];

    logic [W-1:0] shadow [N];
    logic [W-1:0] active [N];
    logic         mem_init = 1'b0;

    always #5 clk = ~clk;

    pwm_sched #(.PWM_WIDTH(W), .NUM_PWM(N)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
        .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .commit(commit), .commit_pending(commit_pending),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_latch(mem_latch), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .pwm_out(pwm_out), .period_start(period_start), .dbg_state(dbg_state)
    );

    pwm_sched #(.PWM_WIDTH(W), .NUM_PWM(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .enable(en5), .period(period5),
        .cfg_valid(cfg5_valid), .cfg_addr(cfg5_addr), .cfg_data(cfg5_data),
        .cfg_ready(cfg5_ready), .commit(commit5), .commit_pending(pending5),
        .mem_we(mem5_we), .mem_waddr(mem5_waddr), .mem_wdata(mem5_wdata),
        .mem_latch(mem5_latch), .mem_raddr(mem5_raddr), .mem_rdata(mem5_rdata),
        .pwm_out(pwm5_out), .period_start(period5_start), .dbg_state(dbg5_state)
    );

    // Shadow bank takes host writes; active bank is loaded on mem_latch.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < N; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (mem_we) shadow[mem_waddr] <= mem_wdata;
            if (mem_latch) for (int i = 0; i < N; i++) active[i] <= shadow[i];
        end
    end
    assign mem_rdata = active[mem_raddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] mk(input logic [1:0] st, input logic ps, input logic ml,
                                      input logic [1:0] ra, input logic [3:0] pw);
        return {st, ps, ml, ra, pw};
    endfunction

    task automatic push_idle();
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 2'd0, 4'd0));
    endtask

    // One LATCH cycle, N LOAD cycles, then run_len RUN cycles from counter 0.
    task automatic push_period(input logic latch, input thr_t t, input int run_len);
        logic [3:0] pw;
        exp_q.push_back(mk(2'd1, 1'b0, latch, 2'd0, 4'd0));
        for (int i = 0; i < N; i++) exp_q.push_back(mk(2'd2, 1'b0, 1'b0, 2'(i), 4'd0));
        for (int c = 0; c < run_len; c++) begin
            for (int i = 0; i < N; i++) pw[i] = (c < int'(t[i]));
            exp_q.push_back(mk(2'd3, c == 0, 1'b0, 2'd0, pw));
        end
    endtask

    always @(negedge clk) begin
        logic [9:0] w;
        if (rst_n) begin
            check("we_latch_overlap", 32'(mem_we & mem_latch), 32'd0);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("cycle_word", 32'({dbg_state, period_start, mem_latch, mem_raddr, pwm_out}),
                      32'(w));
            end
        end
    end

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Drop enable during the final expected cycle so the block parks in IDLE.
    task automatic stop_at_end();
        int n = 0;
        while (exp_q.size() > 1 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("stop_align", 32'(exp_q.size()), 32'd1);
        enable = 1'b0;
        wait_empty();
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        int n = 0;
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!cfg_ready && n < 100);
        check("write_we", 32'(mem_we), 32'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic commit_pulse();
        @(posedge clk); #1;
        commit = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0;
    endtask

    typedef struct {
        logic         valid;
        logic [2:0]   addr;
        logic [W-1:0] data;
        logic         exp_we;
        logic         exp_ready;
    } vec_t;

    initial begin
        vec_t vecs[6];
        thr_t t1;
        thr_t t2;

        vecs[0] = '{1'b1, 3'd0, 16'h1111, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 3'd4, 16'h2222, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 3'd5, 16'h3333, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 3'd6, 16'h4444, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 3'd7, 16'h5555, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 3'd1, 16'h6666, 1'b0, 1'b1};
        t1 = '{16'd0, 16'd3, 16'd10, 16'd12};
        t2 = '{16'd0, 16'd5, 16'd7, 16'd12};

        // Reset state
        repeat (2) @(posedge clk);
        mem_init = 1'b1;
        @(posedge clk); #1;
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_raddr", 32'(mem_raddr), 32'd0);
        check("rst_latch", 32'(mem_latch), 32'd0);
        check("rst_pstart", 32'(period_start), 32'd0);
        check("rst_pending", 32'(commit_pending), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_ready5", 32'(cfg5_ready), 32'd1);
        rst_n = 1'b1;

        // Address range filtering on the 5-channel instance
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            cfg5_valid = vecs[i].valid;
            cfg5_addr  = vecs[i].addr;
            cfg5_data  = vecs[i].data;
            #1;
            check("tbl_we", 32'(mem5_we), 32'(vecs[i].exp_we));
            check("tbl_ready", 32'(cfg5_ready), 32'(vecs[i].exp_ready));
            check("tbl_wdata", 32'(mem5_wdata), 32'(vecs[i].data));
        end
        cfg5_valid = 1'b0;

        // Load {0,3,10,12}, commit, two periods of 10 RUN cycles
        cfg_write(2'd0, 16'd0);
        cfg_write(2'd1, 16'd3);
        cfg_write(2'd2, 16'd10);
        cfg_write(2'd3, 16'd12);
        commit_pulse();
        @(negedge clk);
        check("pending_set", 32'(commit_pending), 32'd1);
        check("pending_ready", 32'(cfg_ready), 32'd0);
        period = 16'd9;
        @(posedge clk); #1;
        enable = 1'b1;
        push_idle();
        push_period(1'b1, t1, 10);
        push_period(1'b0, t1, 10);
        stop_at_end();
        @(negedge clk);
        check("pending_clear", 32'(commit_pending), 32'd0);
        check("ready_after", 32'(cfg_ready), 32'd1);

        // Write stalled while pending, accepted in first LOAD cycle;
        // then a write and commit in the same cycle
        commit_pulse();
        cfg_valid = 1'b1;
        cfg_addr  = 2'd2;
        cfg_data  = 16'd7;
        @(negedge clk);
        check("stall_ready", 32'(cfg_ready), 32'd0);
        check("stall_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        enable = 1'b1;
        push_idle();
        push_period(1'b1, t1, 10);
        push_period(1'b1, t2, 10);
        @(negedge clk);
        check("stall_idle_ready", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        check("stall_latch_ready", 32'(cfg_ready), 32'd0);
        check("stall_latch_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("load0_ready", 32'(cfg_ready), 32'd1);
        check("load0_we", 32'(mem_we), 32'd1);
        check("load0_waddr", 32'(mem_waddr), 32'd2);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_addr  = 2'd1;
        cfg_data  = 16'd5;
        commit    = 1'b1;
        @(negedge clk);
        check("commit_write_we", 32'(mem_we), 32'd1);
        check("commit_write_pend0", 32'(commit_pending), 32'd0);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        commit    = 1'b0;
        @(negedge clk);
        check("commit_write_pend1", 32'(commit_pending), 32'd1);
        stop_at_end();

        // Period changed mid-RUN takes effect at the next boundary
        period = 16'd9;
        @(posedge clk); #1;
        enable = 1'b1;
        push_idle();
        push_period(1'b0, t2, 10);
        push_period(1'b0, t2, 5);
        repeat (8) begin
            @(posedge clk); #1;
        end
        period = 16'd4;
        stop_at_end();

        // Single-cycle RUN
        period = 16'd0;
        @(posedge clk); #1;
        enable = 1'b1;
        push_idle();
        push_period(1'b0, t2, 1);
        stop_at_end();

        // enable dropped at counter 3
        period = 16'd9;
        @(posedge clk); #1;
        enable = 1'b1;
        push_idle();
        push_period(1'b0, t2, 4);
        push_idle();
        repeat (9) begin
            @(posedge clk); #1;
        end
        enable = 1'b0;
        wait_empty();

        // Reset mid-RUN, then restart without a swap
        enable = 1'b1;
        push_idle();
        push_period(1'b0, t2, 3);
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("pre_reset_pwm", 32'(pwm_out), 32'b1110);
        rst_n = 1'b0;
        #1;
        check("reset_pwm_now", 32'(pwm_out), 32'd0);
        check("reset_state_now", 32'(dbg_state), 32'd0);
        check("reset_ready_now", 32'(cfg_ready), 32'd1);
        check("reset_pstart_now", 32'(period_start), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_idle();
        push_period(1'b0, t2, 10);
        stop_at_end();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout want completion at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
